// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
//
// Configuration-chain programmer. Bytes arrive over a valid/ready handshake
// and are serialised LSB-first onto the configuration flip-flop chain head.
// Exactly CHAIN_LEN bits are shifted per load, after which config_done is
// raised. The old chain contents coming out of ccff_tail are folded into a
// running parity for readback checking.
//
// Ports:
//   prog_clk       programming clock, rising-edge active
//   pReset         asynchronous active-high reset
//   start          single-cycle request to begin a load (IDLE/DONE only)
//   data_in        bitstream byte, bit 0 shifted first
//   data_valid     data_in is valid
//   data_ready     loader accepts a byte this cycle (FETCH state)
//   ccff_head      registered serial bit into the chain
//   ccff_shift_en  registered chain shift enable
//   ccff_tail      chain tail output
//   bits_loaded    bits shifted since the last start
//   busy           load in progress
//   config_done    all CHAIN_LEN bits shifted; sticky until start/reset
//   tail_parity    XOR of ccff_tail over every shift_en edge

module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = 16
) (
    input  logic             prog_clk,
    input  logic             pReset,
    input  logic             start,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ccff_head,
    output logic             ccff_shift_en,
    input  logic             ccff_tail,
    output logic [CNT_W-1:0] bits_loaded,
    output logic             busy,
    output logic             config_done,
    output logic             tail_parity
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);

    state_t           state;
    state_t           state_next;
    logic [7:0]       shift_buf;
    logic [3:0]       bit_idx;
    logic [CNT_W-1:0] bits_next;
    logic             accept;
    logic             launch;

    assign bits_next = bits_loaded + CNT_W'(1);

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs. The CHAIN_LEN check takes priority over
    // the end-of-byte check so the high bits of a final partial byte are
    // never shifted.
    always_comb begin
        state_next = state;
        data_ready = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        launch     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    launch     = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                busy       = 1'b1;
                data_ready = 1'b1;
                if (data_valid) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (bits_next == CHAIN_LEN_C) begin
                    state_next = DONE;
                end else if (bit_idx == 4'd7) begin
                    // this cycle's increment brings the bit index to 8
                    state_next = FETCH;
                end
            end
            DONE: begin
                if (start) begin
                    launch     = 1'b1;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. Head and shift enable are registered, so each bit leaves one
    // cycle after its SHIFT cycle; the last pulse therefore lands in DONE,
    // and config_done is set on that pulse so it appears one cycle later.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            shift_buf     <= '0;
            bit_idx       <= '0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            bits_loaded   <= '0;
            config_done   <= 1'b0;
            tail_parity   <= 1'b0;
        end else begin
            ccff_shift_en <= (state == SHIFT);
            if (state == SHIFT) begin
                ccff_head   <= shift_buf[0];
                shift_buf   <= {1'b0, shift_buf[7:1]};
                bit_idx     <= bit_idx + 4'd1;
                bits_loaded <= bits_next;
            end
            if (accept) begin
                shift_buf <= data_in;
                bit_idx   <= '0;
            end
            if (launch) begin
                bits_loaded <= '0;
                tail_parity <= 1'b0;
                config_done <= 1'b0;
            end else begin
                if (ccff_shift_en) begin
                    tail_parity <= tail_parity ^ ccff_tail;
                end
                if ((state == DONE) && ccff_shift_en) begin
                    config_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader
//
// Bench for ccff_bitstream_loader. A CHAIN_LEN=20 instance is driven by a
// table of full loads against a behavioural chain model; expected head bits
// are queued as each byte is offered and popped by a monitor on every
// shift_en cycle. A CHAIN_LEN=8 instance covers the single-byte load, and
// hand-written sequences cover asynchronous reset mid-load.

module tb_ccff_bitstream_loader;

    localparam int CL = 20;
    localparam int CW = 16;

    logic          prog_clk = 1'b0;
    logic          pReset;

    logic          start;
    logic [7:0]    data_in;
    logic          data_valid;
    logic          data_ready;
    logic          ccff_head;
    logic          ccff_shift_en;
    logic          ccff_tail;
    logic [CW-1:0] bits_loaded;
    logic          busy;
    logic          config_done;
    logic          tail_parity;

    logic          start8;
    logic [7:0]    data8;
    logic          valid8;
    logic          ready8;
    logic          head8;
    logic          shift8;
    logic          tail8;
    logic [CW-1:0] bits8;
    logic          busy8;
    logic          done8;
    logic          parity8;

    typedef struct {
        logic [7:0]    b0;
        logic [7:0]    b1;
        logic [7:0]    b2;
        int            gap;
        bit            usePreload;
        logic [CL-1:0] preload;
        bit            midStart;
    } vec_t;

    vec_t          vecs[5];
    int            vectors = 0;
    int            miscompares = 0;
    logic          expQ[$];
    int            pulseCount = 0;
    int            budget = 0;
    logic [CL-1:0] chain;
    logic [CL-1:0] preloadVal;
    bit            preloadReq = 1'b0;
    logic [CL-1:0] prevStream;

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader #(.CHAIN_LEN(CL), .CNT_W(CW)) u_dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .bits_loaded   (bits_loaded),
        .busy          (busy),
        .config_done   (config_done),
        .tail_parity   (tail_parity)
    );

    ccff_bitstream_loader #(.CHAIN_LEN(8), .CNT_W(CW)) u_dut8 (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start8),
        .data_in       (data8),
        .data_valid    (valid8),
        .data_ready    (ready8),
        .ccff_head     (head8),
        .ccff_shift_en (shift8),
        .ccff_tail     (tail8),
        .bits_loaded   (bits8),
        .busy          (busy8),
        .config_done   (done8),
        .tail_parity   (parity8)
    );

    // Behavioural configuration chain: head enters at bit 0, tail is the MSB.
    assign ccff_tail = chain[CL-1];
    always @(posedge prog_clk) begin
        if (preloadReq) begin
            chain <= preloadVal;
        end else if (ccff_shift_en === 1'b1) begin
            chain <= {chain[CL-2:0], ccff_head};
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: timed out waiting, got no event, expected one", name);
    endtask

    // Every shift_en cycle must carry the next queued head bit.
    always @(negedge prog_clk) begin
        if (ccff_shift_en === 1'b1) begin
            pulseCount++;
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL head_extra: got shift_en pulse %0d, expected none", pulseCount);
            end else begin
                checkOutput("head", ccff_head, expQ.pop_front());
            end
        end
    end

    function automatic logic [CL-1:0] streamOf(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [23:0] s;
        s = {c, b, a};
        return s[CL-1:0];
    endfunction

    // The first bit shifted ends up deepest, at the tail end of the chain.
    function automatic logic [CL-1:0] chainOf(input logic [CL-1:0] s);
        logic [CL-1:0] r;
        for (int i = 0; i < CL; i++) r[CL-1-i] = s[i];
        return r;
    endfunction

    // Offer one byte, queueing the bits of it that still fit in the chain,
    // and return at the falling edge after it has been accepted.
    task automatic applyStimulus(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 8 && budget > 0; i++) begin
            expQ.push_back(b[i]);
            budget--;
        end
        data_in    = b;
        data_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (data_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge prog_clk);
        end
        if (!ok) begin
            reportTimeout("byte_accept");
        end else begin
            @(posedge prog_clk);
            @(negedge prog_clk);
        end
    endtask

    task automatic startLoad();
        expQ.delete();
        pulseCount = 0;
        budget     = CL;
        start      = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        checkOutput("start_clears_done", config_done, 0);
        checkOutput("start_clears_count", bits_loaded, 0);
        checkOutput("start_clears_parity", tail_parity, 0);
        checkOutput("fetch_busy", busy, 1);
        checkOutput("fetch_ready", data_ready, 1);
    endtask

    task automatic gapWait(input int n);
        bit ok;
        if (n > 0) begin
            ok         = 1'b0;
            data_valid = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (data_ready === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge prog_clk);
            end
            if (!ok) reportTimeout("gap_fetch");
            @(negedge prog_clk);
            for (int i = 0; i < n; i++) begin
                checkOutput("gap_ready", data_ready, 1);
                checkOutput("gap_shift_en", ccff_shift_en, 0);
                @(negedge prog_clk);
            end
        end
    endtask

    task automatic runLoad(input vec_t v);
        logic          expPar;
        logic [CL-1:0] stream;
        logic [CW-1:0] bl;
        logic          lastShift;
        logic          readySeen;
        bit            found;
        if (v.usePreload) begin
            preloadVal = v.preload;
            preloadReq = 1'b1;
            @(negedge prog_clk);
            preloadReq = 1'b0;
            expPar     = ^v.preload;
        end else begin
            expPar = ^prevStream;
        end
        stream = streamOf(v.b0, v.b1, v.b2);
        startLoad();
        applyStimulus(v.b0);
        if (v.midStart) begin
            @(negedge prog_clk);
            @(negedge prog_clk);
            bl    = bits_loaded;
            start = 1'b1;
            @(negedge prog_clk);
            start = 1'b0;
            checkOutput("midstart_busy", busy, 1);
            checkOutput("midstart_count", bits_loaded, bl + 1);
        end
        gapWait(v.gap);
        applyStimulus(v.b1);
        gapWait(v.gap);
        applyStimulus(v.b2);
        lastShift = 1'b0;
        readySeen = 1'b0;
        found     = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (config_done === 1'b1) begin
                found = 1'b1;
                break;
            end
            lastShift = ccff_shift_en;
            readySeen = readySeen | data_ready;
            @(negedge prog_clk);
        end
        if (!found) begin
            reportTimeout("config_done");
        end else begin
            checkOutput("done_after_last_pulse", lastShift, 1);
            checkOutput("shift_en_low_at_done", ccff_shift_en, 0);
        end
        checkOutput("ready_after_last_byte", readySeen, 0);
        checkOutput("pulse_count", pulseCount, CL);
        checkOutput("bits_loaded_final", bits_loaded, CL);
        checkOutput("tail_parity", tail_parity, expPar);
        checkOutput("done_busy", busy, 0);
        checkOutput("done_ready", data_ready, 0);
        checkOutput("chain_contents", chain, chainOf(stream));
        checkOutput("queue_drained", expQ.size(), 0);
        prevStream = stream;
    endtask

    initial begin
        logic [7:0] got8;
        int         cnt8;
        logic       ready8Seen;
        bit         found;

        vecs[0] = '{b0: 8'hA5, b1: 8'h3C, b2: 8'h0F, gap: 0, usePreload: 1'b1, preload: 20'hABCDE, midStart: 1'b0};
        vecs[1] = '{b0: 8'hA5, b1: 8'h3C, b2: 8'h0F, gap: 5, usePreload: 1'b0, preload: 20'h0,     midStart: 1'b0};
        vecs[2] = '{b0: 8'h7F, b1: 8'h00, b2: 8'h00, gap: 0, usePreload: 1'b0, preload: 20'h0,     midStart: 1'b1};
        vecs[3] = '{b0: 8'h13, b1: 8'h57, b2: 8'h9B, gap: 2, usePreload: 1'b0, preload: 20'h0,     midStart: 1'b0};
        vecs[4] = '{b0: 8'hFF, b1: 8'hFF, b2: 8'hFF, gap: 0, usePreload: 1'b1, preload: 20'h00001, midStart: 1'b0};

        pReset     = 1'b1;
        start      = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        start8     = 1'b0;
        data8      = 8'h00;
        valid8     = 1'b0;
        tail8      = 1'b0;
        prevStream = '0;

        @(negedge prog_clk);
        @(negedge prog_clk);
        checkOutput("reset_ready", data_ready, 0);
        checkOutput("reset_head", ccff_head, 0);
        checkOutput("reset_shift_en", ccff_shift_en, 0);
        checkOutput("reset_bits", bits_loaded, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", config_done, 0);
        checkOutput("reset_parity", tail_parity, 0);
        pReset = 1'b0;
        @(negedge prog_clk);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_ready", data_ready, 0);

        // Single-byte load on the 8-bit chain; data_valid stays high to show
        // no further byte is fetched once DONE is reached.
        start8 = 1'b1;
        @(negedge prog_clk);
        start8 = 1'b0;
        data8  = 8'h81;
        valid8 = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ready8 === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge prog_clk);
        end
        if (!found) reportTimeout("dut8_accept");
        @(posedge prog_clk);
        @(negedge prog_clk);
        got8       = 8'h00;
        cnt8       = 0;
        ready8Seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (shift8 === 1'b1) begin
                if (cnt8 < 8) got8[cnt8] = head8;
                cnt8++;
            end
            ready8Seen = ready8Seen | ready8;
            @(negedge prog_clk);
        end
        valid8 = 1'b0;
        checkOutput("dut8_pulses", cnt8, 8);
        checkOutput("dut8_head_seq", got8, 8'h81);
        checkOutput("dut8_no_refetch", ready8Seen, 0);
        checkOutput("dut8_done", done8, 1);
        checkOutput("dut8_bits", bits8, 8);
        checkOutput("dut8_busy", busy8, 0);

        for (int i = 0; i < 5; i++) begin
            runLoad(vecs[i]);
        end

        // Asynchronous reset in the middle of the second byte.
        preloadVal = 20'hABCDE;
        preloadReq = 1'b1;
        @(negedge prog_clk);
        preloadReq = 1'b0;
        startLoad();
        applyStimulus(8'hA5);
        applyStimulus(8'h3C);
        data_valid = 1'b0;
        found      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bits_loaded == CW'(11)) begin
                found = 1'b1;
                break;
            end
            @(negedge prog_clk);
        end
        if (!found) reportTimeout("bits_loaded_11");
        checkOutput("pre_reset_busy", busy, 1);
        #2;
        pReset = 1'b1;
        #1;
        checkOutput("async_ready", data_ready, 0);
        checkOutput("async_head", ccff_head, 0);
        checkOutput("async_shift_en", ccff_shift_en, 0);
        checkOutput("async_bits", bits_loaded, 0);
        checkOutput("async_busy", busy, 0);
        checkOutput("async_done", config_done, 0);
        checkOutput("async_parity", tail_parity, 0);
        expQ.delete();
        @(negedge prog_clk);
        pReset     = 1'b0;
        data_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge prog_clk);
            checkOutput("post_reset_shift_en", ccff_shift_en, 0);
            checkOutput("post_reset_busy", busy, 0);
            checkOutput("post_reset_ready", data_ready, 0);
        end
        runLoad(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
